// File: rtl/cpu_ctrl_seq_if.sv
// cpu_ctrl_seq_if: instruction-fetch port between the sequencer and instruction memory.
// Latency: none, wires only.
// Backpressure: the sequencer holds req and addr until memory answers with ack; data is valid with ack.
interface cpu_ctrl_seq_if #(
  parameter int PC_W = 4
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [7:0]      data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/decode/execute sequencer for the 4-bit CPU, drives operand mux select, ALU op, write strobe, PC.
// Latency: 3 cycles per instruction minimum (FETCH with same-cycle ack, DECODE, EXEC).
// Backpressure: fetch request and address held until imem ack; FETCH_TMO cycles without ack -> FAULT (terminal).
// Build option CTRL_SINGLE_STEP_EN: adds input step and a PAUSE state entered after every EXEC.
module cpu_ctrl_seq #(
  parameter int PC_W      = 4,
  parameter int FETCH_TMO = 15
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic           step,
`endif
  cpu_ctrl_seq_if.master imem,
  input  logic           alu_z,
  output logic           sel1,
  output logic           sel0,
  output logic [1:0]     alu_op,
  output logic           reg_we,
  output logic [1:0]     reg_wa,
  output logic           halted,
  output logic           fault
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_HALT   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;

`ifdef CTRL_SINGLE_STEP_EN
  localparam logic [2:0] S_AFTER_EXEC = S_PAUSE;
`else
  localparam logic [2:0] S_AFTER_EXEC = S_FETCH;
`endif

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hD;
  localparam logic [3:0] OP_JZ  = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  // Last wait-count value before the fetch is declared dead.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_tgt;
  logic [7:0]      ir;
  logic [3:0]      opc;
  logic            z_flag;
  logic            req_q;
  logic [7:0]      wcnt;
  logic            fetch_ok;
  logic            fetch_wait;

  assign opc        = ir[7:4];
  assign pc_inc     = pc + PC_W'(1);
  // Jump target is the 4-bit immediate; any upper PC bits are cleared.
  assign jmp_tgt    = PC_W'(ir[3:0]);
  // An ack only counts while our request is actually on the wire.
  assign fetch_ok   = (state == S_FETCH) && req_q && imem.ack;
  assign fetch_wait = (state == S_FETCH) && req_q && !imem.ack;

  // Next state and next PC.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_FETCH: begin
        if (fetch_ok)
          state_nx = S_DECODE;
        else if (fetch_wait && (wcnt == TMO_LAST))
          state_nx = S_FAULT;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_HLT:  pc_nx = pc;
          OP_JMP:  pc_nx = jmp_tgt;
          OP_JZ:   pc_nx = z_flag ? jmp_tgt : pc_inc;
          default: pc_nx = pc_inc;
        endcase
        state_nx = (opc == OP_HLT) ? S_HALT : S_AFTER_EXEC;
      end
      S_PAUSE: begin
`ifdef CTRL_SINGLE_STEP_EN
        if (step)
          state_nx = S_FETCH;
`else
        state_nx = S_FETCH;
`endif
      end
      S_HALT:  state_nx = S_HALT;
      S_FAULT: state_nx = S_FAULT;
      // Illegal encodings park in FAULT so software sees a dead sequencer rather than garbage.
      default: state_nx = S_FAULT;
    endcase
  end

  // Sequencer state, PC, IR, zero flag, registered fetch request and fetch wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      z_flag <= 1'b0;
      req_q  <= 1'b0;
      wcnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      // Request is registered so it stays low during reset and rises one cycle after release.
      req_q <= (state_nx == S_FETCH);
      if (fetch_ok)
        ir <= imem.data;
      if ((state == S_EXEC) && ((opc == OP_ADD) || (opc == OP_SUB)))
        z_flag <= alu_z;
      if (fetch_wait)
        wcnt <= wcnt + 8'd1;
      else
        wcnt <= '0;
    end
  end

  // Write strobe and ALU op exist only in EXEC of MOV/ADD/SUB.
  always_comb begin
    reg_we = 1'b0;
    alu_op = 2'b00;
    if (state == S_EXEC) begin
      case (opc)
        OP_MOV: reg_we = 1'b1;
        OP_ADD: begin
          reg_we = 1'b1;
          alu_op = 2'b01;
        end
        OP_SUB: begin
          reg_we = 1'b1;
          alu_op = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Operand select comes straight from IR, which is loaded on the fetch ack, so it is valid from DECODE through EXEC.
  assign sel1      = ir[3];
  assign sel0      = ir[2];
  assign reg_wa    = ir[1:0];
  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign halted    = (state == S_HALT) || (state == S_FAULT);
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: scoreboard bench for cpu_ctrl_seq with an instruction-level reference model.
// Stimulus acts as instruction memory with random ack delays; a monitor checks fetch addresses and write strobes.
// Directed phases cover reset, MOV timing, JZ/JMP/wrap, HLT, fetch timeout and reset during EXEC.
module tb_cpu_ctrl_seq;
  localparam int PC_W      = 4;
  localparam int FETCH_TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_z = 1'b0;
  logic       sel1, sel0, reg_we, halted, fault;
  logic [1:0] alu_op, reg_wa;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  cpu_ctrl_seq_if #(.PC_W(PC_W)) imem ();

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.PC_W(PC_W), .FETCH_TMO(FETCH_TMO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step   (step),
`endif
    .imem   (imem),
    .alu_z  (alu_z),
    .sel1   (sel1),
    .sel0   (sel0),
    .alu_op (alu_op),
    .reg_we (reg_we),
    .reg_wa (reg_wa),
    .halted (halted),
    .fault  (fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]      prog   [16];
  bit              prog_z [16];
  logic [PC_W-1:0] exp_fetch [$];
  logic [5:0]      exp_exec  [$];   // {sel, reg_wa, alu_op}
  bit              mon_en  = 1'b0;
  logic            req_prev = 1'b0;
  bit              noise   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({imem.req, imem.addr, sel1, sel0, alu_op, reg_we, reg_wa, halted, fault});
  endfunction

  // Monitor: each new fetch request and each write strobe consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (imem.req && !req_prev) begin
        if (exp_fetch.size() == 0) check("fetch_unexpected", 32'(imem.addr), 32'hFFFF);
        else check("fetch_addr", 32'(imem.addr), 32'(exp_fetch.pop_front()));
      end
      if (reg_we) begin
        if (exp_exec.size() == 0) check("write_unexpected", 32'({sel1, sel0, reg_wa, alu_op}), 32'hFFFF);
        else check("write_ctl", 32'({sel1, sel0, reg_wa, alu_op}), 32'(exp_exec.pop_front()));
      end
      if (fault) check("fault_in_run", 32'(fault), 32'd0);
    end
    req_prev <= imem.req;
  end

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    imem.ack  = 1'b0;
    imem.data = 8'h00;
    alu_z     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int cyc = 0;
    while (!imem.req && cyc < 20) begin
      imem.ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem.data = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    imem.ack = 1'b0;
    ok = imem.req;
  endtask

  // Runs prog[] through the DUT; the model executes the ISA and queues expected fetches and writes.
  task automatic run_prog(input int max_instr);
    int         mpc;
    bit         mz;
    bit         halt_seen;
    bit         ok;
    int         cyc;
    logic [7:0] ins;
    do_reset();
    exp_fetch.delete();
    exp_exec.delete();
    mpc = 0; mz = 1'b0; halt_seen = 1'b0;
    exp_fetch.push_back(PC_W'(0));
    mon_en = 1'b1;
    for (int k = 0; k < max_instr && !halt_seen; k++) begin
      wait_req(ok);
      if (!ok) begin
        check("req_timeout", 32'(imem.req), 32'd1);
        break;
      end
      ins = prog[mpc];
      case (ins[7:4])
        4'h1: begin exp_exec.push_back({ins[3:0], 2'b00}); mpc = (mpc + 1) % 16; end
        4'h2: begin exp_exec.push_back({ins[3:0], 2'b01}); mz = prog_z[mpc]; mpc = (mpc + 1) % 16; end
        4'h3: begin exp_exec.push_back({ins[3:0], 2'b10}); mz = prog_z[mpc]; mpc = (mpc + 1) % 16; end
        4'hD: halt_seen = 1'b1;
        4'hE: mpc = mz ? int'(ins[3:0]) : (mpc + 1) % 16;
        4'hF: mpc = int'(ins[3:0]);
        default: mpc = (mpc + 1) % 16;
      endcase
      if (!halt_seen) exp_fetch.push_back(PC_W'(mpc));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      imem.ack  = 1'b1;
      imem.data = prog[imem.addr];
      alu_z     = prog_z[imem.addr];
      @(negedge clk);
      imem.ack  = 1'b0;
      imem.data = 8'($urandom);
    end
    if (halt_seen) begin
      repeat (3) @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_fault", 32'(fault), 32'd0);
      cyc = 0;
      repeat (10) begin
        if (imem.req) cyc++;
        @(negedge clk);
      end
      check("halt_req_idle", 32'(cyc), 32'd0);
    end else begin
      cyc = 0;
      while ((exp_fetch.size() != 0 || exp_exec.size() != 0) && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("queues_drained", 32'(exp_fetch.size() + exp_exec.size()), 32'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    imem.ack  = 1'b0;
    imem.data = 8'h00;

    // Reset, then reset again mid-fetch for 3 cycles.
    repeat (2) @(negedge clk);
    check("rst_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_req", 32'(imem.req), 32'd1);
    check("rst_first_addr", 32'(imem.addr), 32'd0);
    rst_n = 1'b0;
    #1 check("rst_mid_fetch_outputs", outs(), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_held_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_req_addr", 32'({imem.req, imem.addr}), 32'h10);

    // MOV 8'h16 with immediate ack: src=01, dst=10.
    do_reset();
    wait_req(ok);
    check("mov_req_addr0", 32'({imem.req, imem.addr}), 32'h10);
    imem.ack = 1'b1; imem.data = 8'h16;
    @(negedge clk);
    imem.ack = 1'b0; imem.data = 8'h00;
    check("mov_dec_sel", 32'({sel1, sel0}), 32'd1);
    check("mov_dec_we_req", 32'({reg_we, imem.req}), 32'd0);
    @(negedge clk);
    check("mov_exec_we", 32'(reg_we), 32'd1);
    check("mov_exec_ctl", 32'({sel1, sel0, reg_wa, alu_op}), 32'({2'b01, 2'b10, 2'b00}));
    @(negedge clk);
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
    n = 0;
    repeat (10) begin
      if (imem.req) n++;
      @(negedge clk);
    end
    check("step_idle_req", 32'(n), 32'd0);
    check("step_idle_halted", 32'(halted), 32'd0);
    step = 1'b1;
    @(negedge clk);
`endif
    check("mov_we_one_cycle", 32'(reg_we), 32'd0);
    check("mov_next_fetch", 32'({imem.req, imem.addr}), 32'h11);

    // SUB z=1, JZ -> 7; SUB z=0, JZ falls through; JMP F, NOP at F wraps to 0.
    foreach (prog[i]) begin prog[i] = 8'h00; prog_z[i] = 1'b0; end
    prog[0] = 8'h35; prog_z[0] = 1'b1;
    prog[1] = 8'hE7;
    prog[7] = 8'h3E; prog_z[7] = 1'b0;
    prog[8] = 8'hE2;
    prog[9] = 8'hFF;
    prog[15] = 8'h00;
    run_prog(8);

    // JMP F3 then HLT at 3.
    foreach (prog[i]) begin prog[i] = 8'h00; prog_z[i] = 1'b0; end
    prog[0] = 8'hF3;
    prog[3] = 8'hD0;
    run_prog(5);

    // Withhold ack: fault after exactly FETCH_TMO request cycles.
    do_reset();
    wait_req(ok);
    n = 0;
    while (imem.req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(FETCH_TMO));
    check("tmo_state", 32'({fault, halted, imem.req}), 32'b110);

    // Reset asserted during EXEC of ADD: write strobe drops immediately.
    do_reset();
    wait_req(ok);
    imem.ack = 1'b1; imem.data = 8'h2A;
    @(negedge clk);
    imem.ack = 1'b0;
    @(negedge clk);
    check("exec_we_before_rst", 32'(reg_we), 32'd1);
    rst_n = 1'b0;
    #1 check("exec_rst_outputs", outs(), 32'd0);

    // Random programs with random ack delays and stray acks while idle.
    noise = 1'b1;
    for (int r = 0; r < 8; r++) begin
      foreach (prog[i]) begin prog[i] = 8'($urandom); prog_z[i] = 1'($urandom_range(0, 1)); end
      run_prog(24);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
